// File: rtl/mips_core_pkg.sv
// Shared MIPS core types, widths and latency defaults used by the multiply/divide unit.
package mips_core_pkg;
    localparam int PHYS_REG_INDEX         = 6;
    localparam int ACTIVE_LIST_SIZE_INDEX = 5;
    localparam int MUL_LATENCY_DEFAULT    = 4;
    localparam int DIV_LATENCY_DEFAULT    = 33;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_MULU = 2'd1,
        OP_DIV  = 2'd2,
        OP_DIVU = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        WAIT_WB  = 2'd3
    } mdu_state_t;

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction
endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider, one quotient bit per cycle, with sign fix-up on the outputs.
// Only compiled when MIPS_CORE_MDU_DIV_EN is defined.
`ifdef MIPS_CORE_MDU_DIV_EN
module mdu_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dvs_zero_q, dvs_zero_d;
    logic [32:0] rem_shift;
    logic [32:0] trial;

    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        dvs_zero_d = dvs_zero_q;
        rem_shift  = {rem_q, quo_q[31]};
        trial      = rem_shift - {1'b0, dvs_q};
        if (start) begin
            // Magnitudes are divided; signs are re-applied on the outputs.
            neg_rem_d  = is_signed & dividend[31];
            neg_quo_d  = is_signed & (dividend[31] ^ divisor[31]);
            quo_d      = (is_signed & dividend[31]) ? -dividend : dividend;
            dvs_d      = (is_signed & divisor[31]) ? -divisor : divisor;
            rem_d      = '0;
            cnt_d      = 6'd32;
            dvs_zero_d = (divisor == '0);
        end else if (cnt_q != '0) begin
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = rem_shift[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dvs_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            dvs_zero_q <= dvs_zero_d;
        end
    end

    // A zero divisor leaves |dividend| in the remainder, so the sign fix-up restores op1 exactly.
    assign done      = (cnt_q == '0);
    assign quotient  = dvs_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_q : quo_q);
    assign remainder = neg_rem_q ? -rem_q : rem_q;
endmodule
`endif

// File: rtl/mdu_controller.sv
// Multiply/divide unit controller: accepts one op, sequences it and shares the write-back port with the ALU.
// Build macro MIPS_CORE_MDU_DIV_EN enables the divider; without it DIV/DIVU write back zero after MUL_LATENCY.
module mdu_controller
    import mips_core_pkg::*;
#(
    parameter int MUL_LATENCY  = MUL_LATENCY_DEFAULT,
    parameter int DIV_LATENCY  = DIV_LATENCY_DEFAULT,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  mdu_op_t                           req_op,
    input  logic [31:0]                       req_op1,
    input  logic [31:0]                       req_op2,
    input  logic [ACTIVE_LIST_SIZE_INDEX-1:0] req_id,
    input  logic [PHYS_REG_INDEX-1:0]         req_rw_addr,
    input  logic                              flush,
    input  logic                              alu_wb_valid,
    output logic                              wb_valid,
    output logic [PHYS_REG_INDEX-1:0]         wb_rw_addr,
    output logic [ACTIVE_LIST_SIZE_INDEX-1:0] wb_id,
    output logic [31:0]                       wb_hi,
    output logic [31:0]                       wb_lo,
    output logic                              commit_valid,
    output logic                              block_alu,
    output logic                              busy
);
    localparam int MAX_LAT  = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W    = $clog2(MAX_LAT + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    mdu_state_t                        state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [STARVE_W-1:0]               starve_q, starve_d;
    mdu_op_t                           op_q, op_d;
    logic [31:0]                       op1_q, op1_d, op2_q, op2_d;
    logic [31:0]                       hi_q, hi_d, lo_q, lo_d;
    logic [ACTIVE_LIST_SIZE_INDEX-1:0] id_q, id_d;
    logic [PHYS_REG_INDEX-1:0]         rw_addr_q, rw_addr_d;
    logic                              accept;
    logic [63:0]                       mul_a, mul_b, product;
    logic                              div_done;
    logic [31:0]                       div_hi, div_lo;

    assign accept = req_valid & req_ready;

`ifdef MIPS_CORE_MDU_DIV_EN
    localparam int DIV_CYCLES = DIV_LATENCY;

    mdu_divider u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && is_div_op(req_op)),
        .is_signed (req_op == OP_DIV),
        .dividend  (req_op1),
        .divisor   (req_op2),
        .done      (div_done),
        .quotient  (div_lo),
        .remainder (div_hi)
    );
`else
    localparam int DIV_CYCLES = MUL_LATENCY;

    assign div_done = 1'b1;
    assign div_hi   = '0;
    assign div_lo   = '0;
`endif

    // One 64x64 multiplier serves both signednesses; the low 64 bits are exact either way.
    assign mul_a   = (op_q == OP_MUL) ? {{32{op1_q[31]}}, op1_q} : {32'b0, op1_q};
    assign mul_b   = (op_q == OP_MUL) ? {{32{op2_q[31]}}, op2_q} : {32'b0, op2_q};
    assign product = mul_a * mul_b;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        op_d      = op_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        id_d      = id_q;
        rw_addr_d = rw_addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = req_op;
                    op1_d     = req_op1;
                    op2_d     = req_op2;
                    id_d      = req_id;
                    rw_addr_d = req_rw_addr;
                    if (is_div_op(req_op)) begin
                        state_d = DIV_BUSY;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end else begin
                        state_d = MUL_BUSY;
                        cnt_d   = CNT_W'(MUL_LATENCY - 1);
                    end
                end
            end
            MUL_BUSY: begin
                if (cnt_q == '0) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    state_d = WAIT_WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (div_done) begin
                    hi_d    = div_hi;
                    lo_d    = div_lo;
                    state_d = WAIT_WB;
                end
            end
            WAIT_WB: begin
                if (alu_wb_valid && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
                    starve_d = starve_q + 1'b1;
                end
                if (wb_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        if (state_d != WAIT_WB) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            starve_q  <= '0;
            op_q      <= OP_MUL;
            op1_q     <= '0;
            op2_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            id_q      <= '0;
            rw_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            op_q      <= op_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            id_q      <= id_d;
            rw_addr_q <= rw_addr_d;
        end
    end

    // Outputs are gated by rst_n so they read zero from the very cycle reset is asserted.
    assign req_ready    = rst_n && (state_q == IDLE) && !flush;
    assign wb_valid     = rst_n && (state_q == WAIT_WB) && !alu_wb_valid && !flush;
    assign commit_valid = wb_valid;
    assign block_alu    = rst_n && (state_q == WAIT_WB) && (starve_q == STARVE_W'(STARVE_LIMIT));
    assign busy         = rst_n && (state_q != IDLE);
    assign wb_hi        = rst_n ? hi_q : '0;
    assign wb_lo        = rst_n ? lo_q : '0;
    assign wb_id        = rst_n ? id_q : '0;
    assign wb_rw_addr   = rst_n ? rw_addr_q : '0;
endmodule

// File: tb/tb_mdu_controller.sv
// Directed self-checking bench for mdu_controller; expectations follow MIPS_CORE_MDU_DIV_EN.
module tb_mdu_controller;
    import mips_core_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              req_valid;
    logic                              req_ready;
    mdu_op_t                           req_op;
    logic [31:0]                       req_op1, req_op2;
    logic [ACTIVE_LIST_SIZE_INDEX-1:0] req_id;
    logic [PHYS_REG_INDEX-1:0]         req_rw_addr;
    logic                              flush;
    logic                              alu_wb_valid;
    logic                              wb_valid;
    logic [PHYS_REG_INDEX-1:0]         wb_rw_addr;
    logic [ACTIVE_LIST_SIZE_INDEX-1:0] wb_id;
    logic [31:0]                       wb_hi, wb_lo;
    logic                              commit_valid;
    logic                              block_alu;
    logic                              busy;

    int checks   = 0;
    int failures = 0;

`ifdef MIPS_CORE_MDU_DIV_EN
    localparam int EXP_DIV_LAT = 33;
    localparam bit DIV_ON      = 1'b1;
`else
    localparam int EXP_DIV_LAT = 4;
    localparam bit DIV_ON      = 1'b0;
`endif

    always #5 clk = ~clk;

    mdu_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_id       (req_id),
        .req_rw_addr  (req_rw_addr),
        .flush        (flush),
        .alu_wb_valid (alu_wb_valid),
        .wb_valid     (wb_valid),
        .wb_rw_addr   (wb_rw_addr),
        .wb_id        (wb_id),
        .wb_hi        (wb_hi),
        .wb_lo        (wb_lo),
        .commit_valid (commit_valid),
        .block_alu    (block_alu),
        .busy         (busy)
    );

    // Offers one op for a single edge; returns #1 after that edge.
    task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [ACTIVE_LIST_SIZE_INDEX-1:0] id,
                         input logic [PHYS_REG_INDEX-1:0] addr);
        req_valid   = 1'b1;
        req_op      = op;
        req_op1     = a;
        req_op2     = b;
        req_id      = id;
        req_rw_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until wb_valid; -1 if it never comes.
    task automatic wait_wb(output int lat);
        lat = -1;
        for (int k = 1; k <= 80 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (wb_valid === 1'b1) lat = k;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_op = OP_MUL; req_op1 = 32'd1; req_op2 = 32'd1;
        req_id = '0; req_rw_addr = '0; flush = 1'b0; alu_wb_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready);
        end
        checks++;
        if ({wb_valid, commit_valid, block_alu, busy} !== 4'b0000) begin
            failures++; $display("[TB] FAIL reset_status: got %b expected 0000", {wb_valid, commit_valid, block_alu, busy});
        end
        checks++;
        if ({wb_hi, wb_lo, wb_id, wb_rw_addr} !== '0) begin
            failures++; $display("[TB] FAIL reset_data: got %h expected 0", {wb_hi, wb_lo, wb_id, wb_rw_addr});
        end
        req_valid = 1'b0; rst_n = 1'b1; #1;
        checks++;
        if ({req_ready, busy} !== 2'b10) begin
            failures++; $display("[TB] FAIL reset_release: got ready,busy=%b expected 10", {req_ready, busy});
        end
    endtask

    task automatic test_mul();
        mdu_op_t     ops [3] = '{OP_MUL, OP_MULU, OP_MUL};
        logic [31:0] as  [3] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [63:0] exp [3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], ACTIVE_LIST_SIZE_INDEX'(5 + i), PHYS_REG_INDEX'(9 + i));
            wait_wb(lat);
            checks++;
            if (lat !== 4) begin
                failures++; $display("[TB] FAIL mul%0d_latency: got %0d expected 4", i, lat);
            end
            checks++;
            if ({wb_hi, wb_lo} !== exp[i]) begin
                failures++; $display("[TB] FAIL mul%0d_result: got %h expected %h", i, {wb_hi, wb_lo}, exp[i]);
            end
            checks++;
            if (wb_id !== ACTIVE_LIST_SIZE_INDEX'(5 + i) || wb_rw_addr !== PHYS_REG_INDEX'(9 + i)) begin
                failures++; $display("[TB] FAIL mul%0d_tags: got id=%0d addr=%0d expected id=%0d addr=%0d",
                                     i, wb_id, wb_rw_addr, 5 + i, 9 + i);
            end
            checks++;
            if (commit_valid !== 1'b1) begin
                failures++; $display("[TB] FAIL mul%0d_commit: got %b expected 1", i, commit_valid);
            end
            @(posedge clk); #1;
            checks++;
            if ({busy, wb_valid, req_ready} !== 3'b001) begin
                failures++; $display("[TB] FAIL mul%0d_idle: got busy,wb,ready=%b expected 001", i, {busy, wb_valid, req_ready});
            end
        end
    endtask

    task automatic test_div();
        mdu_op_t     ops [6] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FFFB};
        logic [31:0] bs  [6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'd0};
        logic [31:0] his [6] = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'd2, 32'd1, 32'hFFFF_FFFB};
        logic [31:0] los [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        logic [31:0] exp_hi, exp_lo;
        int lat;
        for (int i = 0; i < 6; i++) begin
            exp_hi = DIV_ON ? his[i] : 32'd0;
            exp_lo = DIV_ON ? los[i] : 32'd0;
            issue(ops[i], as[i], bs[i], ACTIVE_LIST_SIZE_INDEX'(20 + i), PHYS_REG_INDEX'(40 + i));
            wait_wb(lat);
            checks++;
            if (lat !== EXP_DIV_LAT) begin
                failures++; $display("[TB] FAIL div%0d_latency: got %0d expected %0d", i, lat, EXP_DIV_LAT);
            end
            checks++;
            if (wb_hi !== exp_hi || wb_lo !== exp_lo) begin
                failures++; $display("[TB] FAIL div%0d_result: got hi=%h lo=%h expected hi=%h lo=%h",
                                     i, wb_hi, wb_lo, exp_hi, exp_lo);
            end
            checks++;
            if (wb_id !== ACTIVE_LIST_SIZE_INDEX'(20 + i)) begin
                failures++; $display("[TB] FAIL div%0d_id: got %0d expected %0d", i, wb_id, 20 + i);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_starve();
        bit early_wb = 1'b0;
        alu_wb_valid = 1'b1;
        issue(OP_MULU, 32'd3, 32'd4, ACTIVE_LIST_SIZE_INDEX'(7), PHYS_REG_INDEX'(20));
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            if (wb_valid !== 1'b0) early_wb = 1'b1;
        end
        checks++;
        if (early_wb || block_alu !== 1'b0) begin
            failures++; $display("[TB] FAIL starve_before_limit: got early_wb=%b block_alu=%b expected 0 0", early_wb, block_alu);
        end
        @(posedge clk); #1;
        checks++;
        if ({block_alu, wb_valid} !== 2'b10) begin
            failures++; $display("[TB] FAIL starve_block_rise: got block,wb=%b expected 10", {block_alu, wb_valid});
        end
        @(posedge clk); #1;
        alu_wb_valid = 1'b0; #1;
        checks++;
        if ({wb_valid, block_alu} !== 2'b11 || {wb_hi, wb_lo} !== 64'd12) begin
            failures++; $display("[TB] FAIL starve_release: got wb,block=%b data=%h expected 11 data=%h",
                                 {wb_valid, block_alu}, {wb_hi, wb_lo}, 64'd12);
        end
        @(posedge clk); #1;
        checks++;
        if ({block_alu, busy} !== 2'b00) begin
            failures++; $display("[TB] FAIL starve_after: got block,busy=%b expected 00", {block_alu, busy});
        end
    endtask

    task automatic test_flush();
        bit seen_wb = 1'b0;
        issue(OP_DIV, 32'd100, 32'd3, ACTIVE_LIST_SIZE_INDEX'(2), PHYS_REG_INDEX'(3));
        @(posedge clk); #1;
        flush = 1'b1; #1;
        checks++;
        if ({req_ready, busy} !== 2'b01) begin
            failures++; $display("[TB] FAIL flush_during_busy: got ready,busy=%b expected 01", {req_ready, busy});
        end
        @(posedge clk); #1;
        flush = 1'b0; #1;
        checks++;
        if ({req_ready, busy} !== 2'b10) begin
            failures++; $display("[TB] FAIL flush_next_ready: got ready,busy=%b expected 10", {req_ready, busy});
        end
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (wb_valid !== 1'b0) seen_wb = 1'b1;
        end
        checks++;
        if (seen_wb) begin
            failures++; $display("[TB] FAIL flush_no_wb: got wb_valid=1 expected never");
        end
        flush = 1'b1; req_valid = 1'b1; req_op = OP_MUL; req_op1 = 32'd2; req_op2 = 32'd2; #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_with_req_ready: got %b expected 0", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0; #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_with_req_accepted: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_flush_wb();
        int lat;
        issue(OP_MUL, 32'd2, 32'd2, ACTIVE_LIST_SIZE_INDEX'(4), PHYS_REG_INDEX'(4));
        wait_wb(lat);
        checks++;
        if (lat !== 4) begin
            failures++; $display("[TB] FAIL flush_wb_latency: got %0d expected 4", lat);
        end
        flush = 1'b1; #1;
        checks++;
        if ({wb_valid, commit_valid} !== 2'b00) begin
            failures++; $display("[TB] FAIL flush_wb_suppress: got wb,commit=%b expected 00", {wb_valid, commit_valid});
        end
        @(posedge clk); #1;
        flush = 1'b0; #1;
        checks++;
        if ({busy, wb_valid, req_ready} !== 3'b001) begin
            failures++; $display("[TB] FAIL flush_wb_idle: got busy,wb,ready=%b expected 001", {busy, wb_valid, req_ready});
        end
    endtask

    task automatic test_reset_mid();
        bit seen_wb = 1'b0;
        issue(OP_MUL, 32'd6, 32'd7, ACTIVE_LIST_SIZE_INDEX'(3), PHYS_REG_INDEX'(4));
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        checks++;
        if ({req_ready, busy} !== 2'b00) begin
            failures++; $display("[TB] FAIL reset_mid_during: got ready,busy=%b expected 00", {req_ready, busy});
        end
        @(posedge clk); #1;
        checks++;
        if ({req_ready, wb_valid, commit_valid, block_alu, busy, wb_hi, wb_lo, wb_id, wb_rw_addr} !== '0) begin
            failures++; $display("[TB] FAIL reset_mid_outputs: got %h expected 0",
                                 {req_ready, wb_valid, commit_valid, block_alu, busy, wb_hi, wb_lo, wb_id, wb_rw_addr});
        end
        rst_n = 1'b1; #1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (wb_valid !== 1'b0 || busy !== 1'b0) seen_wb = 1'b1;
        end
        checks++;
        if (seen_wb || wb_lo !== 32'd0) begin
            failures++; $display("[TB] FAIL reset_mid_abandon: got activity=%b lo=%h expected 0 0", seen_wb, wb_lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(OP_MUL, 32'd2, 32'd3, ACTIVE_LIST_SIZE_INDEX'(1), PHYS_REG_INDEX'(1));
        wait_wb(lat);
        checks++;
        if (lat !== 4 || wb_lo !== 32'd6) begin
            failures++; $display("[TB] FAIL b2b_first: got lat=%0d lo=%h expected 4 %h", lat, wb_lo, 32'd6);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL b2b_ready: got %b expected 1", req_ready);
        end
        issue(OP_MULU, 32'd10, 32'd10, ACTIVE_LIST_SIZE_INDEX'(2), PHYS_REG_INDEX'(2));
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("[TB] FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        wait_wb(lat);
        checks++;
        if (lat !== 4 || wb_lo !== 32'd100 || wb_id !== ACTIVE_LIST_SIZE_INDEX'(2)) begin
            failures++; $display("[TB] FAIL b2b_second: got lat=%0d lo=%h id=%0d expected 4 %h 2", lat, wb_lo, wb_id, 32'd100);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_starve();
        test_flush();
        test_flush_wb();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
